// File: rtl/cnn_pool2_stage_if.sv
// Stream bundle between the conv result stream, the 2x2 pooling stage and its consumer.
// The slave modport is the pooling stage's view; master is the producer/consumer side.
interface cnn_pool2_stage_if #(
  parameter int DW = 32,
  parameter int CH = 16
);
  logic              in_en;
  logic [CH*DW-1:0]  in_data;
  logic              out_en;
  logic [CH*DW-1:0]  out_data;
  logic [7:0]        out_row;
  logic [7:0]        out_col;
  logic              frame_done;

  modport master (
    output in_en, in_data,
    input  out_en, out_data, out_row, out_col, frame_done
  );

  modport slave (
    input  in_en, in_data,
    output out_en, out_data, out_row, out_col, frame_done
  );
endinterface

// File: rtl/cnn_pool2_stage.sv
// 2x2 stride-2 signed max pooling over a raster-order CH-channel stream, one W/2 line buffer.
// Optional macro POOL_RELU_EN clamps negative pooled channels to zero before the output register.
module cnn_pool2_stage #(
  parameter int DW = 32,
  parameter int CH = 16,
  parameter int W  = 26,
  parameter int H  = 26
) (
  input  logic              clk,
  input  logic              rst,
  cnn_pool2_stage_if.slave  pool_if
);

  localparam int HALF_W = W / 2;
  localparam int HALF_H = H / 2;
  localparam int AW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;

  localparam logic [7:0] COL_LAST  = 8'(W - 1);
  localparam logic [7:0] ROW_LAST  = 8'(H - 1);
  localparam logic [7:0] COL_PAIRS = 8'(2 * HALF_W);
  localparam logic [7:0] ROW_PAIRS = 8'(2 * HALF_H);
  localparam logic [6:0] OCOL_LAST = 7'(HALF_W - 1);
  localparam logic [6:0] OROW_LAST = 7'(HALF_H - 1);

  logic [7:0]       col_q, col_d;
  logic [7:0]       row_q, row_d;
  logic [CH*DW-1:0] hreg_q;
  logic [CH*DW-1:0] rd_q;
  logic [CH*DW-1:0] hmax;
  logic [CH*DW-1:0] pooled;
  logic [CH*DW-1:0] linebuf [HALF_W];

  logic             out_en_q;
  logic [CH*DW-1:0] out_data_q;
  logic [7:0]       out_row_q;
  logic [7:0]       out_col_q;
  logic             frame_done_q;

  logic          col_odd, row_odd;
  logic          lb_rd, lb_wr, fire, last_win;
  logic [AW-1:0] lb_addr;

  assign col_odd = col_q[0];
  assign row_odd = row_q[0];
  assign lb_addr = col_q[AW:1];

  // Trailing column/row of an odd-sized map never pairs up, so it only moves the counters.
  assign lb_rd    = pool_if.in_en && row_odd && !col_odd && (col_q < COL_PAIRS);
  assign lb_wr    = pool_if.in_en && !row_odd && col_odd && (row_q < ROW_PAIRS);
  assign fire     = pool_if.in_en && row_odd && col_odd;
  assign last_win = (row_q[7:1] == OROW_LAST) && (col_q[7:1] == OCOL_LAST);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (pool_if.in_en) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 8'd1;
      end else begin
        col_d = col_q + 8'd1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
      logic signed [DW-1:0] smp, hr, hm, lb, pm;
      assign smp = pool_if.in_data[gi*DW +: DW];
      assign hr  = hreg_q[gi*DW +: DW];
      assign lb  = rd_q[gi*DW +: DW];
      assign hm  = (hr > smp) ? hr : smp;
      assign pm  = (lb > hm) ? lb : hm;
      assign hmax[gi*DW +: DW] = hm;
`ifdef POOL_RELU_EN
      assign pooled[gi*DW +: DW] = pm[DW-1] ? '0 : pm;
`else
      assign pooled[gi*DW +: DW] = pm;
`endif
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q        <= '0;
      row_q        <= '0;
      hreg_q       <= '0;
      out_en_q     <= 1'b0;
      out_data_q   <= '0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      out_en_q     <= fire;
      frame_done_q <= fire && last_win;
      if (pool_if.in_en && !col_odd)
        hreg_q <= pool_if.in_data;
      if (fire) begin
        out_data_q <= pooled;
        out_row_q  <= {1'b0, row_q[7:1]};
        out_col_q  <= {1'b0, col_q[7:1]};
      end
    end
  end

  // Odd-row read is issued on the even column so the odd column finds it already registered.
  always_ff @(posedge clk) begin
    if (lb_wr)
      linebuf[lb_addr] <= hmax;
    if (lb_rd)
      rd_q <= linebuf[lb_addr];
  end

  assign pool_if.out_en     = out_en_q;
  assign pool_if.out_data   = out_data_q;
  assign pool_if.out_row    = out_row_q;
  assign pool_if.out_col    = out_col_q;
  assign pool_if.frame_done = frame_done_q;

endmodule

// File: tb/tb_cnn_pool2_stage.sv
// Self-checking bench for cnn_pool2_stage: image-array reference model, one task per scenario.
// Honours POOL_RELU_EN the same way as the design build.
module tb_cnn_pool2_stage;
  localparam int DW = 32, CH = 16, W = 26, H = 26;
  localparam int PH = H / 2, PW = W / 2, NWIN = PH * PW;

  typedef struct {
    logic [CH*DW-1:0] data;
    int               row;
    int               col;
    bit               done;
    int               cyc;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cnn_pool2_stage_if #(.DW(DW), .CH(CH)) bus ();
  cnn_pool2_stage #(.DW(DW), .CH(CH), .W(W), .H(H)) dut (.clk(clk), .rst(rst), .pool_if(bus));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic signed [DW-1:0] img [H][W][CH];
  logic [CH*DW-1:0]     ramp_ref [NWIN];
  rec_t exp_q[$];
  rec_t obs_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  always @(negedge clk) begin
    rec_t r;
    if (bus.out_en || bus.frame_done) begin
      r.data = bus.out_data; r.row = int'(bus.out_row); r.col = int'(bus.out_col);
      r.done = bus.frame_done; r.cyc = cyc;
      obs_q.push_back(r);
    end
  end

  // Reference: signed max over the 2x2 window of the stored image, optional ReLU.
  function automatic logic [CH*DW-1:0] window(int pr, int pc);
    logic [CH*DW-1:0] v;
    logic signed [DW-1:0] m;
    for (int k = 0; k < CH; k++) begin
      m = img[2*pr][2*pc][k];
      for (int dr = 0; dr < 2; dr++)
        for (int dc = 0; dc < 2; dc++)
          if (img[2*pr+dr][2*pc+dc][k] > m) m = img[2*pr+dr][2*pc+dc][k];
`ifdef POOL_RELU_EN
      if (m < 0) m = 0;
`endif
      v[k*DW +: DW] = m;
    end
    return v;
  endfunction

  task automatic fill_ramp(int offset);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        for (int k = 0; k < CH; k++) img[r][c][k] = DW'(r*W + c + k + offset);
  endtask

  // Drives up to nsamp samples of img; leaves in_en high after the last one.
  task automatic run_frame(int max_gap, int nsamp);
    int n = 0;
    rec_t e;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (n == nsamp) return;
        @(posedge clk); #1;
        bus.in_en = 1'b1;
        for (int k = 0; k < CH; k++) bus.in_data[k*DW +: DW] = img[r][c][k];
        if ((r % 2 == 1) && (c % 2 == 1) && (r < 2*PH) && (c < 2*PW)) begin
          e.data = window(r/2, c/2); e.row = r/2; e.col = c/2;
          e.done = (r/2 == PH-1) && (c/2 == PW-1); e.cyc = cyc + 1;
          exp_q.push_back(e);
        end
        n++;
        if (max_gap > 0)
          repeat ($urandom_range(0, max_gap)) begin
            @(posedge clk); #1; bus.in_en = 1'b0;
            bus.in_data = {CH{DW'($urandom)}};
          end
      end
  endtask

  task automatic idle(int n);
    @(posedge clk); #1; bus.in_en = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_q();
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset();
    bus.in_en = 1'b0; bus.in_data = '0; rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.out_en !== 1'b0) begin n_fail++; $display("FAIL reset_out_en got %b want 0", bus.out_en); end
    n_checks++; if (bus.out_data !== '0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", bus.out_data); end
    n_checks++; if (bus.out_row !== 8'd0) begin n_fail++; $display("FAIL reset_out_row got %0d want 0", bus.out_row); end
    n_checks++; if (bus.out_col !== 8'd0) begin n_fail++; $display("FAIL reset_out_col got %0d want 0", bus.out_col); end
    n_checks++; if (bus.frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done got %b want 0", bus.frame_done); end
    rst = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_ramp();
    clear_q(); fill_ramp(0); run_frame(0, H*W); idle(4);
    n_checks++; if (obs_q.size() != NWIN || exp_q.size() != NWIN) begin
      n_fail++; $display("FAIL ramp_count got %0d want %0d", obs_q.size(), NWIN); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i].data !== exp_q[i].data || obs_q[i].row != exp_q[i].row || obs_q[i].col != exp_q[i].col ||
          obs_q[i].done !== exp_q[i].done || obs_q[i].cyc != exp_q[i].cyc) begin
        n_fail++; $display("FAIL ramp_win%0d got (%0d,%0d) done=%b cyc=%0d want (%0d,%0d) done=%b cyc=%0d", i,
          obs_q[i].row, obs_q[i].col, obs_q[i].done, obs_q[i].cyc, exp_q[i].row, exp_q[i].col, exp_q[i].done, exp_q[i].cyc);
      end
      if (i < NWIN) ramp_ref[i] = exp_q[i].data;
    end
    if (obs_q.size() == NWIN) begin
      n_checks++; if (obs_q[0].data[0 +: DW] !== 32'd27) begin n_fail++; $display("FAIL ramp_w00_ch0 got %0d want 27", obs_q[0].data[0 +: DW]); end
      n_checks++; if (obs_q[0].data[15*DW +: DW] !== 32'd42) begin n_fail++; $display("FAIL ramp_w00_ch15 got %0d want 42", obs_q[0].data[15*DW +: DW]); end
      n_checks++; if (obs_q[NWIN-1].data[0 +: DW] !== 32'd675) begin n_fail++; $display("FAIL ramp_w1212_ch0 got %0d want 675", obs_q[NWIN-1].data[0 +: DW]); end
      n_checks++; if (obs_q[NWIN-1].done !== 1'b1) begin n_fail++; $display("FAIL ramp_frame_done got %b want 1", obs_q[NWIN-1].done); end
    end
    $display("test_ramp done: %0d pulses", obs_q.size());
  endtask

  task automatic test_negative();
    logic [DW-1:0] want3;
    clear_q();
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) for (int k = 0; k < CH; k++) img[r][c][k] = 32'hFFFFFF00;
    img[1][1][3] = 32'hFFFFFFF0;
`ifdef POOL_RELU_EN
    want3 = 32'h0;
`else
    want3 = 32'hFFFFFFF0;
`endif
    run_frame(0, H*W); idle(4);
    n_checks++; if (obs_q.size() != NWIN) begin n_fail++; $display("FAIL neg_count got %0d want %0d", obs_q.size(), NWIN); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i].data !== exp_q[i].data) begin
        n_fail++; $display("FAIL neg_win%0d got %h want %h", i, obs_q[i].data, exp_q[i].data); end
    end
    if (obs_q.size() > 0) begin
      n_checks++; if (obs_q[0].data[3*DW +: DW] !== want3) begin
        n_fail++; $display("FAIL neg_w00_ch3 got %h want %h", obs_q[0].data[3*DW +: DW], want3); end
    end
    $display("test_negative done");
  endtask

  task automatic test_bubbles();
    clear_q(); fill_ramp(0); run_frame(5, H*W); idle(4);
    n_checks++; if (obs_q.size() != NWIN) begin n_fail++; $display("FAIL bub_count got %0d want %0d", obs_q.size(), NWIN); end
    for (int i = 0; i < obs_q.size() && i < NWIN; i++) begin
      n_checks++;
      if (obs_q[i].data !== ramp_ref[i] || obs_q[i].cyc != exp_q[i].cyc || obs_q[i].row != exp_q[i].row ||
          obs_q[i].col != exp_q[i].col) begin
        n_fail++; $display("FAIL bub_win%0d got (%0d,%0d) cyc=%0d want (%0d,%0d) cyc=%0d", i,
          obs_q[i].row, obs_q[i].col, obs_q[i].cyc, exp_q[i].row, exp_q[i].col, exp_q[i].cyc);
      end
    end
    $display("test_bubbles done");
  endtask

  task automatic test_back_to_back();
    int ndone = 0;
    logic bad;
    clear_q(); fill_ramp(0); run_frame(0, H*W);
    fill_ramp(1000); run_frame(0, H*W); idle(4);
    n_checks++; if (obs_q.size() != 2*NWIN) begin n_fail++; $display("FAIL b2b_count got %0d want %0d", obs_q.size(), 2*NWIN); end
    foreach (obs_q[i]) if (obs_q[i].done) ndone++;
    n_checks++; if (ndone != 2) begin n_fail++; $display("FAIL b2b_frame_done got %0d want 2", ndone); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i].data !== exp_q[i].data || obs_q[i].cyc != exp_q[i].cyc) begin
        n_fail++; $display("FAIL b2b_win%0d got cyc=%0d want cyc=%0d", i, obs_q[i].cyc, exp_q[i].cyc); end
    end
    if (obs_q.size() == 2*NWIN)
      for (int i = 0; i < NWIN; i++) begin
        bad = 1'b0;
        for (int k = 0; k < CH; k++)
          if (obs_q[NWIN+i].data[k*DW +: DW] !== obs_q[i].data[k*DW +: DW] + 32'd1000) bad = 1'b1;
        n_checks++;
        if (bad) begin n_fail++; $display("FAIL b2b_plus1000_win%0d got %h want frame1+1000", i, obs_q[NWIN+i].data); end
      end
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_mid_frame();
    clear_q(); fill_ramp(0); run_frame(0, 300);
    @(posedge clk); #1; rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (bus.out_en !== 1'b0 || bus.out_data !== '0 || bus.out_row !== 8'd0 || bus.out_col !== 8'd0 || bus.frame_done !== 1'b0) begin
        n_fail++; $display("FAIL midrst_outputs got en=%b row=%0d col=%0d done=%b want all 0",
          bus.out_en, bus.out_row, bus.out_col, bus.frame_done);
      end
    end
    bus.in_en = 1'b0; rst = 1'b1;
    clear_q();
    run_frame(0, H*W); idle(4);
    n_checks++; if (obs_q.size() != NWIN) begin n_fail++; $display("FAIL midrst_count got %0d want %0d", obs_q.size(), NWIN); end
    for (int i = 0; i < obs_q.size() && i < NWIN; i++) begin
      n_checks++;
      if (obs_q[i].data !== ramp_ref[i] || obs_q[i].row != exp_q[i].row || obs_q[i].col != exp_q[i].col ||
          obs_q[i].done !== exp_q[i].done) begin
        n_fail++; $display("FAIL midrst_win%0d got (%0d,%0d) want (%0d,%0d)", i,
          obs_q[i].row, obs_q[i].col, exp_q[i].row, exp_q[i].col);
      end
    end
    $display("test_reset_mid_frame done");
  endtask

  task automatic test_extreme_random();
    logic [DW-1:0] ext [4];
    int p;
    clear_q();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        for (int k = 0; k < CH; k++)
          img[r][c][k] = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 3)) : DW'($urandom);
    ext[0] = 32'h7FFFFFFF; ext[1] = 32'h80000000; ext[2] = 32'h0; ext[3] = 32'h1;
    for (int k = 0; k < CH; k++) begin
      p = int'($urandom_range(0, 3));
      for (int j = 0; j < 4; j++) img[j/2][j%2][k] = ext[(j + p) % 4];
    end
    run_frame(2, H*W); idle(4);
    n_checks++; if (obs_q.size() != NWIN) begin n_fail++; $display("FAIL rnd_count got %0d want %0d", obs_q.size(), NWIN); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i].data !== exp_q[i].data || obs_q[i].cyc != exp_q[i].cyc) begin
        n_fail++; $display("FAIL rnd_win%0d got %h want %h", i, obs_q[i].data, exp_q[i].data); end
    end
    if (obs_q.size() > 0)
      for (int k = 0; k < CH; k++) begin
        n_checks++;
        if (obs_q[0].data[k*DW +: DW] !== 32'h7FFFFFFF) begin
          n_fail++; $display("FAIL extreme_ch%0d got %h want 7fffffff", k, obs_q[0].data[k*DW +: DW]); end
      end
    $display("test_extreme_random done");
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_negative();
    test_bubbles();
    test_back_to_back();
    test_reset_mid_frame();
    test_extreme_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
